motor_stop_guard: RTL and testbench

MOTOR_STOP_GUARD -- requirements
Module: motor_stop_guard

---
 rtl/motor_stop_guard.sv | 167 ++++++++++++++++
 tb/tb_motor_stop_guard.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/motor_stop_guard.sv
// motor_stop_guard: arms motor PWM after a sustained operator request, forces
// the motors off on a stop command (and, when built with
// MOTOR_STOP_GUARD_WDT_EN, on loss of the flight-controller heartbeat), and
// latches the stop cause until the operator clears it with all requests low.
module motor_stop_guard #(
  parameter int N_CH    = 4,
  parameter int ARM_CYC = 1000000,
  parameter int WDT_CYC = 50000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] pwm_in,
  input  logic            arm_req,
  input  logic            stop_req,
  input  logic            clr_req,
  input  logic            heartbeat,
  output logic [N_CH-1:0] pwm_out,
  output logic            stop,
  output logic [1:0]      stop_cause,
  output logic [9:0]      led
);

  typedef enum logic [1:0] {
    DISARMED = 2'b00,
    ARMING   = 2'b01,
    ARMED    = 2'b10,
    STOPPED  = 2'b11
  } state_t;

  localparam int             AW       = $clog2(ARM_CYC);
  localparam logic [AW-1:0]  ARM_LAST = AW'(ARM_CYC - 1);

  state_t          state, state_nxt;
  logic            started;
  logic [AW-1:0]   arm_cnt, arm_cnt_nxt;
  logic [1:0]      cause, cause_nxt;
  logic            hb_seen, hb_seen_nxt;
  logic            timeout;
  logic [1:0]      state_code;
  logic [N_CH-1:0] pwm_p1;

`ifdef MOTOR_STOP_GUARD_WDT_EN
  localparam int             WW       = $clog2(WDT_CYC);
  localparam logic [WW-1:0]  WDT_LAST = WW'(WDT_CYC - 1);

  logic [WW-1:0] wdt_cnt, wdt_cnt_nxt;

  // Timeout fires once the counter has sat at its last value; a heartbeat in
  // the same cycle rescues the link.
  always_comb begin
    timeout = (state == ARMED) && !heartbeat && (wdt_cnt == WDT_LAST);
  end

  // Counter is held at zero outside ARMED so every entry to ARMED starts fresh;
  // it saturates rather than wrapping.
  always_comb begin
    wdt_cnt_nxt = wdt_cnt;
    if (state != ARMED)
      wdt_cnt_nxt = '0;
    else if (heartbeat)
      wdt_cnt_nxt = '0;
    else if (wdt_cnt != WDT_LAST)
      wdt_cnt_nxt = wdt_cnt + 1'b1;
  end

  // Watchdog counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wdt_cnt <= '0;
    else
      wdt_cnt <= wdt_cnt_nxt;
  end
`else
  // Without the watchdog nothing can time out; stop_cause[1] stays 0.
  always_comb begin
    timeout = 1'b0;
  end
`endif

  // Control state registers; reset forces DISARMED immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= DISARMED;
      started <= 1'b0;
      arm_cnt <= '0;
      cause   <= 2'b00;
      hb_seen <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
      arm_cnt <= arm_cnt_nxt;
      cause   <= cause_nxt;
      hb_seen <= hb_seen_nxt;
    end
  end

  // Next-state, arm counter and cause accumulation. The FSM is frozen for the
  // first edge after reset release so no transition happens before the second.
  always_comb begin
    state_nxt   = state;
    arm_cnt_nxt = arm_cnt;
    cause_nxt   = cause;
    if (started) begin
      case (state)
        DISARMED: begin
          if (arm_req && !stop_req) begin
            state_nxt   = ARMING;
            arm_cnt_nxt = '0;
          end
        end
        ARMING: begin
          if (stop_req) begin
            state_nxt = STOPPED;
            cause_nxt = cause | 2'b01;
          end else if (!arm_req) begin
            state_nxt   = DISARMED;
            arm_cnt_nxt = '0;
          end else if (arm_cnt == ARM_LAST) begin
            state_nxt = ARMED;
          end else begin
            arm_cnt_nxt = arm_cnt + 1'b1;
          end
        end
        ARMED: begin
          if (stop_req || timeout) begin
            state_nxt = STOPPED;
            cause_nxt = cause | {timeout, stop_req};
          end
        end
        STOPPED: begin
          cause_nxt = cause | {1'b0, stop_req};
          if (clr_req && !stop_req && !arm_req) begin
            state_nxt   = DISARMED;
            cause_nxt   = 2'b00;
            arm_cnt_nxt = '0;
          end
        end
        default: state_nxt = DISARMED;
      endcase
    end
  end

  // Heartbeat-seen flag: any pulse sets it, entering DISARMED clears it.
  always_comb begin
    hb_seen_nxt = hb_seen;
    if (heartbeat)
      hb_seen_nxt = 1'b1;
    else if (state_nxt == DISARMED && state != DISARMED)
      hb_seen_nxt = 1'b0;
  end

  // p1: one-cycle PWM register, loaded only while ARMED so re-arming starts low.
  always_ff @(posedge clk) begin
    pwm_p1 <= (state == ARMED) ? pwm_in : '0;
  end

  // Outputs decoded from state so stop and PWM gating follow state (and the
  // asynchronous reset) with no extra register delay.
  always_comb begin
    state_code = state;
    stop       = (state != ARMED);
    pwm_out    = (state == ARMED) ? pwm_p1 : '0;
    stop_cause = cause;
    led        = {5'b00000, hb_seen, cause, state_code};
  end

endmodule

// File: tb/tb_motor_stop_guard.sv
// Directed bench for motor_stop_guard (N_CH=4, ARM_CYC=8, WDT_CYC=16).
// Watchdog steps are included when MOTOR_STOP_GUARD_WDT_EN is defined.
module tb_motor_stop_guard;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pwm_in;
  logic       arm_req, stop_req, clr_req, heartbeat;
  logic [3:0] pwm_out;
  logic       stop;
  logic [1:0] stop_cause;
  logic [9:0] led;

  int checks   = 0;
  int failures = 0;

  motor_stop_guard #(.N_CH(4), .ARM_CYC(8), .WDT_CYC(16)) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .arm_req(arm_req),
    .stop_req(stop_req), .clr_req(clr_req), .heartbeat(heartbeat),
    .pwm_out(pwm_out), .stop(stop), .stop_cause(stop_cause), .led(led)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Enter ARMING then spend 8 cycles counting, leaving the DUT in ARMED.
  task automatic arm_up();
    arm_req = 1'b1;
    tick();
    repeat (8) tick();
    arm_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pwm_in = 4'b1010;
    arm_req = 1'b0; stop_req = 1'b0; clr_req = 1'b0; heartbeat = 1'b0;
    tick();
    chk("rst_pwm",   {28'd0, pwm_out}, 32'h0);
    chk("rst_stop",  {31'd0, stop}, 32'h1);
    chk("rst_cause", {30'd0, stop_cause}, 32'h0);
    chk("rst_led",   {22'd0, led}, 32'h000);
    tick();

    // Release reset with arm_req already high: nothing moves on the first edge.
    reset = 1'b0; arm_req = 1'b1;
    tick();
    chk("rel_edge1_state", {30'd0, led[1:0]}, 32'h0);
    tick();
    chk("rel_edge2_arming", {30'd0, led[1:0]}, 32'h1);

    // Abort arming after 5 cycles.
    repeat (4) tick();
    chk("abort_still_arming", {30'd0, led[1:0]}, 32'h1);
    arm_req = 1'b0;
    tick();
    chk("abort_disarmed", {30'd0, led[1:0]}, 32'h0);
    chk("abort_pwm", {28'd0, pwm_out}, 32'h0);
    chk("abort_stop", {31'd0, stop}, 32'h1);

    // Full arm sequence.
    arm_req = 1'b1;
    tick();
    chk("arm_enter", {30'd0, led[1:0]}, 32'h1);
    repeat (7) tick();
    chk("arm_last_count", {30'd0, led[1:0]}, 32'h1);
    chk("arm_stop_hi", {31'd0, stop}, 32'h1);
    tick();
    chk("armed_led", {22'd0, led}, 32'h002);
    chk("armed_stop", {31'd0, stop}, 32'h0);
    chk("armed_pwm_first", {28'd0, pwm_out}, 32'h0);
    arm_req = 1'b0;
    tick();
    chk("armed_pwm_1010", {28'd0, pwm_out}, 32'ha);
    pwm_in = 4'b0101;
    tick();
    chk("armed_pwm_0101", {28'd0, pwm_out}, 32'h5);

    // Single-cycle stop command.
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    chk("stop_stop", {31'd0, stop}, 32'h1);
    chk("stop_pwm", {28'd0, pwm_out}, 32'h0);
    chk("stop_cause", {30'd0, stop_cause}, 32'h1);
    chk("stop_led", {22'd0, led}, 32'h007);
    repeat (3) tick();
    chk("stop_sticky", {22'd0, led}, 32'h007);

    // Clear attempts: ignored with arm_req or stop_req high, honoured when all low.
    clr_req = 1'b1; arm_req = 1'b1;
    tick();
    chk("clr_with_arm", {30'd0, led[1:0]}, 32'h3);
    arm_req = 1'b0; stop_req = 1'b1;
    tick();
    chk("clr_with_stop", {22'd0, led}, 32'h007);
    stop_req = 1'b0;
    tick();
    clr_req = 1'b0;
    chk("clr_ok_led", {22'd0, led}, 32'h000);
    chk("clr_ok_cause", {30'd0, stop_cause}, 32'h0);

    // Heartbeat indicator, then arm with the flag carried through.
    heartbeat = 1'b1;
    tick();
    heartbeat = 1'b0;
    chk("hb_seen", {22'd0, led}, 32'h010);
    arm_up();
    chk("hb_armed_led", {22'd0, led}, 32'h012);

`ifdef MOTOR_STOP_GUARD_WDT_EN
    // Heartbeat every 10 cycles keeps the link alive.
    for (int i = 0; i < 10; i++) begin
      heartbeat = 1'b1;
      tick();
      heartbeat = 1'b0;
      repeat (9) tick();
    end
    chk("wdt_alive", {30'd0, led[1:0]}, 32'h2);
    repeat (6) tick();
    chk("wdt_edge15_armed", {30'd0, led[1:0]}, 32'h2);
    tick();
    chk("wdt_expired_led", {22'd0, led}, 32'h01b);
    chk("wdt_expired_pwm", {28'd0, pwm_out}, 32'h0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("wdt_clr_led", {22'd0, led}, 32'h000);

    // Watchdog expiry coincident with a stop command.
    arm_up();
    repeat (15) tick();
    chk("both_pre", {30'd0, led[1:0]}, 32'h2);
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    chk("both_cause", {30'd0, stop_cause}, 32'h3);
    chk("both_led", {22'd0, led}, 32'h00f);
`else
    // No watchdog: a silent heartbeat never stops the motors.
    repeat (40) tick();
    chk("nowdt_armed", {30'd0, led[1:0]}, 32'h2);
    chk("nowdt_stop", {31'd0, stop}, 32'h0);
    clr_req = 1'b1; stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    tick();
    clr_req = 1'b0;
    chk("nowdt_clr_led", {22'd0, led}, 32'h000);

    // Stop command with heartbeat: only the command bit can be set.
    arm_up();
    heartbeat = 1'b1; stop_req = 1'b1;
    tick();
    heartbeat = 1'b0; stop_req = 1'b0;
    chk("nowdt_cause", {30'd0, stop_cause}, 32'h1);
    chk("nowdt_led", {22'd0, led}, 32'h017);
`endif

    clr_req = 1'b1; arm_req = 1'b1;
    tick();
    chk("clr2_ignored", {30'd0, led[1:0]}, 32'h3);
    arm_req = 1'b0;
    tick();
    clr_req = 1'b0;
    chk("clr2_led", {22'd0, led}, 32'h000);

    // Asynchronous reset in the middle of ARMED.
    pwm_in = 4'b1111;
    arm_up();
    tick();
    chk("pre_rst_pwm", {28'd0, pwm_out}, 32'hf);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_pwm", {28'd0, pwm_out}, 32'h0);
    chk("async_rst_stop", {31'd0, stop}, 32'h1);
    chk("async_rst_led", {22'd0, led}, 32'h000);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_state", {22'd0, led}, 32'h000);
    chk("post_rst_pwm", {28'd0, pwm_out}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
